// File: rtl/sha256_uart_ctrl.sv
// sha256_uart_ctrl: sequencer between the UART byte streams and the SHA-256
// compression core. It gathers 64 received bytes into one pre-padded block and
// starts the core. When the core finishes, it latches the digest and returns it
// over the UART TX one byte at a time, most significant byte first.
module sha256_uart_ctrl #(
  parameter int BLOCK_BYTES  = 64,
  parameter int DIGEST_BYTES = 32,
  parameter int GAP_TIMEOUT  = 200000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rx_valid,
  input  logic [7:0]                rx_byte,
  output logic                      core_start,
  output logic [8*BLOCK_BYTES-1:0]  block_out,
  input  logic                      core_done,
  input  logic [8*DIGEST_BYTES-1:0] core_digest,
  output logic                      tx_start,
  output logic [7:0]                tx_data,
  input  logic                      tx_busy,
  output logic                      busy,
  output logic                      hash_done,
  output logic                      err_overrun,
  output logic                      err_timeout
);

  localparam int CNT_W = $clog2(BLOCK_BYTES);
  localparam int IDX_W = $clog2(DIGEST_BYTES);
  localparam int GAP_W = $clog2(GAP_TIMEOUT);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BLOCK_BYTES - 1);
  localparam logic [IDX_W-1:0] LAST_DIG  = IDX_W'(DIGEST_BYTES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_TIMEOUT - 1);

  typedef enum logic [2:0] {
    COLLECT,
    START,
    WAIT_CORE,
    SEND,
    WAIT_TX
  } state_t;

  state_t                    state, state_d;
  logic [CNT_W-1:0]          byte_cnt;
  logic [CNT_W-1:0]          wr_idx;
  logic [GAP_W-1:0]          gap_cnt;
  logic [IDX_W-1:0]          dig_idx;
  logic [8*DIGEST_BYTES-1:0] dig_reg;
  logic                      tx_guard;
  logic                      gap_expire;
  logic                      core_start_d;
  logic                      tx_start_d;
  logic                      hash_done_d;

  // A partial block has sat idle for too long; a byte arriving in this very
  // cycle becomes byte 0 of a fresh block instead of extending the old one.
  assign gap_expire  = (state == COLLECT) && (byte_cnt != '0) && (gap_cnt == GAP_LAST);
  assign wr_idx      = gap_expire ? '0 : byte_cnt;
  assign err_timeout = gap_expire;
  assign busy        = !((state == COLLECT) && (byte_cnt == '0));

  // Next-state and next-pulse decode for the sequencer.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d      = state;
    core_start_d = 1'b0;
    tx_start_d   = 1'b0;
    hash_done_d  = 1'b0;
    case (state)
      COLLECT: begin
        if (rx_valid && !gap_expire && (byte_cnt == LAST_BYTE)) state_d = START;
      end
      START: begin
        core_start_d = 1'b1;
        state_d      = WAIT_CORE;
      end
      WAIT_CORE: begin
        if (core_done) state_d = SEND;
      end
      SEND: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          state_d    = WAIT_TX;
        end
      end
      WAIT_TX: begin
        // The UART raises tx_busy only the cycle after it sees tx_start, so the
        // first cycle here cannot trust tx_busy being low.
        if (!tx_guard && !tx_busy) begin
          if (dig_idx == LAST_DIG) begin
            hash_done_d = 1'b1;
            state_d     = COLLECT;
          end else begin
            state_d = SEND;
          end
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // State register, registered pulse outputs and the sticky overrun flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= COLLECT;
      core_start  <= 1'b0;
      tx_start    <= 1'b0;
      hash_done   <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state      <= state_d;
      core_start <= core_start_d;
      tx_start   <= tx_start_d;
      hash_done  <= hash_done_d;
      if (rx_valid && (state != COLLECT)) err_overrun <= 1'b1;
    end
  end

  // Block assembly: byte writes, byte counter and inter-byte gap timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      block_out <= '0;
      byte_cnt  <= '0;
      gap_cnt   <= '0;
    end else if (state == COLLECT) begin
      if (rx_valid) begin
        block_out[(BLOCK_BYTES - 1 - int'(wr_idx)) * 8 +: 8] <= rx_byte;
        // The counter width is exactly log2(BLOCK_BYTES), so accepting the
        // last byte wraps it back to 0 as the block leaves for the core.
        byte_cnt <= wr_idx + CNT_W'(1);
        gap_cnt  <= '0;
      end else if (gap_expire) begin
        byte_cnt <= '0;
        gap_cnt  <= '0;
      end else if (byte_cnt != '0) begin
        gap_cnt <= gap_cnt + GAP_W'(1);
      end
    end
  end

  // Digest capture and byte-serial readout towards the UART TX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig_reg  <= '0;
      dig_idx  <= '0;
      tx_data  <= '0;
      tx_guard <= 1'b0;
    end else begin
      tx_guard <= tx_start_d;
      if ((state == WAIT_CORE) && core_done) begin
        dig_reg <= core_digest;
        dig_idx <= '0;
      end
      if (tx_start_d) tx_data <= dig_reg[(DIGEST_BYTES - 1 - int'(dig_idx)) * 8 +: 8];
      if ((state == WAIT_TX) && (state_d == SEND)) dig_idx <= dig_idx + IDX_W'(1);
    end
  end

endmodule
